// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// master: drives en/up/clr/load/load_val and observes count/tc/ovf.
// slave:  the counter side; consumes the controls and drives the status.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, clr, load, load_val,
        input  count, tc, ovf
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, tc, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Prescaled up/down modulo counter with wrap/saturate, load, clear,
// a combinational terminal count and a registered overflow pulse.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   en, up, clr, load, load_val in; count, tc, ovf out.
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    updown_mod_counter_if.slave bus
);
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             ovf_q, ovf_d;
    logic             at_limit;
    logic             step;

    // Limit depends on the direction requested this cycle.
    assign at_limit = bus.up ? (count_q == MAX_C) : (count_q == '0);
    assign step     = bus.en && (psc_q == PSC_LAST);

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        ovf_d   = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            psc_d   = '0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
            psc_d   = '0;
        end else if (step) begin
            psc_d = '0;
            ovf_d = at_limit;
            if (at_limit) begin
                if (SATURATE)
                    count_d = count_q;
                else
                    count_d = bus.up ? '0 : MAX_C;
            end else if (bus.up) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end else if (bus.en) begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            psc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = at_limit;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (wrap, saturate,
// prescale-by-3, all MAX_VAL=9) driven in lockstep against a model.
module tb_updown_mod_counter;
    logic       clk;
    logic       rst;
    logic       en, up, clr, load;
    logic [3:0] load_val;
    logic [3:0] cnt_o [3];
    logic       tc_o  [3];
    logic       ovf_o [3];

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = wrap, 1 = saturate, 2 = prescale 3.
    int m_cnt [3];
    int m_psc [3];
    bit m_ovf [3];

    localparam int MAXV = 9;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        updown_mod_counter_if #(.WIDTH(4)) bus ();
        assign bus.en       = en;
        assign bus.up       = up;
        assign bus.clr      = clr;
        assign bus.load     = load;
        assign bus.load_val = load_val;
        assign cnt_o[g]     = bus.count;
        assign tc_o[g]      = bus.tc;
        assign ovf_o[g]     = bus.ovf;
        updown_mod_counter #(
            .WIDTH   (4),
            .MAX_VAL (9),
            .PRESCALE((g == 2) ? 3 : 1),
            .SATURATE(g == 1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int psc_of(int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_psc[k] = 0;
            m_ovf[k] = 0;
        end
    endfunction

    function automatic bit model_tc(int k);
        return up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
    endfunction

    function automatic void model_edge();
        bit lim;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            m_ovf[k] = 0;
            if (clr) begin
                m_cnt[k] = 0;
                m_psc[k] = 0;
            end else if (load) begin
                m_cnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                m_psc[k] = 0;
            end else if (en) begin
                m_psc[k] = (m_psc[k] + 1) % psc_of(k);
                if (m_psc[k] == 0) begin
                    lim = model_tc(k);
                    m_ovf[k] = lim;
                    if (up)
                        m_cnt[k] = !lim ? m_cnt[k] + 1 : (k == 1 ? MAXV : 0);
                    else
                        m_cnt[k] = !lim ? m_cnt[k] - 1 : (k == 1 ? 0 : MAXV);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d] count=%0d want 0", k, cnt_o[k]);
            end
        end
        rst = 1'b0;
        load = 1'b1;
        load_val = 4'd7;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== 4'd7) begin
                errors++;
                $display("FAIL pre_reset_load[%0d] count=%0d want 7", k, cnt_o[k]);
            end
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== 4'd0 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset[%0d] count=%0d ovf=%0b want 0/0",
                         k, cnt_o[k], ovf_o[k]);
            end
        end
        tick();
        rst = 1'b0;
        en = 1'b1;
        up = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== ((k == 2) ? 4'd0 : 4'd1)) begin
                errors++;
                $display("FAIL first_step[%0d] count=%0d want %0d",
                         k, cnt_o[k], (k == 2) ? 0 : 1);
            end
        end
    endtask

    task automatic test_up_wrap();
        en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (cnt_o[0] !== 4'(i % 10) || tc_o[0] !== (i % 10 == 9)
                || ovf_o[0] !== (i == 10)) begin
                errors++;
                $display("FAIL up_wrap step %0d count=%0d tc=%0b ovf=%0b want %0d/%0b/%0b",
                         i, cnt_o[0], tc_o[0], ovf_o[0],
                         i % 10, (i % 10 == 9), (i == 10));
            end
            checks++;
            if (cnt_o[2] !== 4'(m_cnt[2])) begin
                errors++;
                $display("FAIL up_wrap_psc step %0d count=%0d want %0d",
                         i, cnt_o[2], m_cnt[2]);
            end
        end
    endtask

    task automatic test_down_sat();
        int exp_c [4] = '{1, 0, 0, 0};
        bit exp_o [4] = '{0, 0, 1, 1};
        load_val = 4'd2;
        load = 1'b1;
        tick();
        load = 1'b0;
        up = 1'b0;
        en = 1'b1;
        checks++;
        if (cnt_o[1] !== 4'd2) begin
            errors++;
            $display("FAIL down_sat_load count=%0d want 2", cnt_o[1]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cnt_o[1] !== 4'(exp_c[i]) || ovf_o[1] !== exp_o[i]) begin
                errors++;
                $display("FAIL down_sat step %0d count=%0d ovf=%0b want %0d/%0b",
                         i, cnt_o[1], ovf_o[1], exp_c[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_prescale();
        int n = 0;
        en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        up = 1'b1;
        for (int i = 0; i < 14; i++) begin
            en = (i < 4 || i >= 9);
            tick();
            if (en)
                n++;
            checks++;
            if (cnt_o[2] !== 4'(n / 3)) begin
                errors++;
                $display("FAIL prescale cycle %0d count=%0d want %0d",
                         i, cnt_o[2], n / 3);
            end
        end
    endtask

    task automatic test_priority();
        en = 1'b1;
        up = 1'b1;
        load_val = 4'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        clr = 1'b1;
        load = 1'b1;
        load_val = 4'd7;
        tick();
        clr = 1'b0;
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== 4'd0 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL clr_over_load[%0d] count=%0d ovf=%0b want 0/0",
                         k, cnt_o[k], ovf_o[k]);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (cnt_o[2] !== ((i == 3) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL clr_psc edge %0d count=%0d want %0d",
                         i, cnt_o[2], (i == 3) ? 1 : 0);
            end
        end
        load_val = 4'd15;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== 4'd9 || tc_o[k] !== 1'b1) begin
                errors++;
                $display("FAIL load_clamp[%0d] count=%0d tc=%0b want 9/1",
                         k, cnt_o[k], tc_o[k]);
            end
        end
    endtask

    task automatic test_dir_flip();
        load_val = 4'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up = (i % 2 == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (cnt_o[k] !== (up ? 4'd6 : 4'd5) || ovf_o[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL dir_flip[%0d] step %0d count=%0d ovf=%0b want %0d/0",
                             k, i, cnt_o[k], ovf_o[k], up ? 6 : 5);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clr  = ($urandom % 25 == 0);
            load = ($urandom % 15 == 0);
            load_val = 4'($urandom % 16);
            en   = ($urandom % 4 != 0);
            if ($urandom % 8 == 0)
                up = ~up;
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cnt_o[k] !== 4'(m_cnt[k]) || ovf_o[k] !== m_ovf[k]
                    || tc_o[k] !== model_tc(k)) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d count=%0d ovf=%0b tc=%0b want %0d/%0b/%0b",
                             k, i, cnt_o[k], ovf_o[k], tc_o[k],
                             m_cnt[k], m_ovf[k], model_tc(k));
                end
            end
        end
        clr = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        up = 1'b1;
        clr = 1'b0;
        load = 1'b0;
        load_val = 4'd0;
        model_reset();
        #12;
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_prescale();
        test_priority();
        test_dir_flip();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
